// File: rtl/secuenciador_bus_rtc.sv
// -----------------------------------------------------------------------------
// secuenciador_bus_rtc
//
// Drives every access on the RTC chip's multiplexed Intel-mode address/data
// bus and arbitrates that bus between PicoBlaze writes, PicoBlaze reads and a
// periodic auto-refresh scan of the time registers.
//
// Each transaction is an address cycle (address latched with a wr_n strobe)
// followed by a data cycle (wr_n for writes, rd_n for reads). Every bus phase
// lasts PHASE_CYCLES clocks. A one-cycle DONE state ends the transaction and
// raises listo plus listo_lee or listo_escribe.
//
// Ports:
//   clk, rst                clock, synchronous active-low reset
//   pb_escribe, pb_lee      one-cycle request pulses from PicoBlaze
//   pb_dir, pb_dato         register address / write data for the requests
//   ad_in                   bus data from the pad
//   ad_out, ad_oe, ad_sel   bus data to the pad, pad enable, address phase
//   cs_n, rd_n, wr_n        active-low chip select / read / write strobes
//   dato_leido, dir_leida   data and address of the last completed read
//   listo*                  one-cycle completion strobes
//   ocupado                 transaction in progress
//   refresco_activo         refresh scan in progress
//
// Handshake: requests are fire-and-forget pulses. Each pulse sets a pending
// flag and overwrites that flag's operands (latest wins); completion is
// reported only through the listo* strobes.
// -----------------------------------------------------------------------------
module secuenciador_bus_rtc #(
    parameter int         PHASE_CYCLES   = 10,
    parameter int         REFRESH_PERIOD = 50000,
    parameter logic [7:0] REFRESH_BASE   = 8'h21,
    parameter int         REFRESH_COUNT  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_escribe,
    input  logic       pb_lee,
    input  logic [7:0] pb_dir,
    input  logic [7:0] pb_dato,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] dato_leido,
    output logic [7:0] dir_leida,
    output logic       listo,
    output logic       listo_lee,
    output logic       listo_escribe,
    output logic       ocupado,
    output logic       refresco_activo
);

    localparam int PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int RF_W = $clog2(REFRESH_PERIOD);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PHASE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_LAST   = RF_W'(REFRESH_PERIOD - 1);
    localparam logic [7:0]      SCAN_LAST = 8'(REFRESH_COUNT - 1);

    // Encoding is sequential so each phase simply advances to state + 1.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR_SET  = 3'd1;
    localparam logic [2:0] S_ADDR_STB  = 3'd2;
    localparam logic [2:0] S_ADDR_HOLD = 3'd3;
    localparam logic [2:0] S_DATA_SET  = 3'd4;
    localparam logic [2:0] S_DATA_STB  = 3'd5;
    localparam logic [2:0] S_DATA_HOLD = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_RF = 2'd2;

    logic [2:0]      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      cur_dir_q, cur_dir_d;
    logic [7:0]      cur_dato_q, cur_dato_d;

    logic            pw_q, pw_d;
    logic            pr_q, pr_d;
    logic            rf_q, rf_d;
    logic [7:0]      pw_dir_q, pw_dir_d;
    logic [7:0]      pw_dato_q, pw_dato_d;
    logic [7:0]      pr_dir_q, pr_dir_d;

    logic [RF_W-1:0] rf_cnt_q, rf_cnt_d;
    logic [7:0]      scan_idx_q, scan_idx_d;
    logic            scan_act_q, scan_act_d;

    logic [7:0]      dato_leido_q, dato_leido_d;
    logic [7:0]      dir_leida_q, dir_leida_d;

    logic            in_addr, in_data, is_wr;
    logic            done_wr, done_rd, done_rf;

    assign is_wr   = (op_q == OP_WR);
    assign done_wr = (state_q == S_DONE) && (op_q == OP_WR);
    assign done_rd = (state_q == S_DONE) && (op_q == OP_RD);
    assign done_rf = (state_q == S_DONE) && (op_q == OP_RF);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        op_d         = op_q;
        cur_dir_d    = cur_dir_q;
        cur_dato_d   = cur_dato_q;
        dato_leido_d = dato_leido_q;
        dir_leida_d  = dir_leida_q;
        scan_idx_d   = scan_idx_q;
        scan_act_d   = scan_act_q;

        // Operands: a pulse this cycle wins over the held value.
        pw_dir_d  = pb_escribe ? pb_dir  : pw_dir_q;
        pw_dato_d = pb_escribe ? pb_dato : pw_dato_q;
        pr_dir_d  = pb_lee     ? pb_dir  : pr_dir_q;

        // The served flag is cleared in DONE; a same-cycle pulse re-arms it.
        pw_d = pw_q;
        if (done_wr)    pw_d = 1'b0;
        if (pb_escribe) pw_d = 1'b1;

        pr_d = pr_q;
        if (done_rd) pr_d = 1'b0;
        if (pb_lee)  pr_d = 1'b1;

        // Free-running refresh timer; rf stays set for the whole scan so each
        // scan read is re-arbitrated and PicoBlaze can slip in between.
        rf_cnt_d = (rf_cnt_q == RF_LAST) ? '0 : rf_cnt_q + RF_W'(1);
        rf_d     = rf_q;
        if (done_rf) begin
            if (scan_idx_q == SCAN_LAST) begin
                rf_d       = 1'b0;
                scan_act_d = 1'b0;
                scan_idx_d = 8'd0;
            end else begin
                scan_idx_d = scan_idx_q + 8'd1;
            end
        end
        if ((rf_cnt_q == RF_LAST) && !scan_act_q) rf_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (pw_q || pb_escribe) begin
                    op_d       = OP_WR;
                    cur_dir_d  = pw_dir_d;
                    cur_dato_d = pw_dato_d;
                    state_d    = S_ADDR_SET;
                end else if (pr_q || pb_lee) begin
                    op_d      = OP_RD;
                    cur_dir_d = pr_dir_d;
                    state_d   = S_ADDR_SET;
                end else if (rf_q) begin
                    op_d       = OP_RF;
                    cur_dir_d  = REFRESH_BASE + scan_idx_q;
                    scan_act_d = 1'b1;
                    state_d    = S_ADDR_SET;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = state_q + 3'd1;
                    // Read data is captured on the last edge of the rd_n strobe.
                    if ((state_q == S_DATA_STB) && !is_wr) begin
                        dato_leido_d = ad_in;
                        dir_leida_d  = cur_dir_q;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            op_q         <= OP_WR;
            cur_dir_q    <= 8'd0;
            cur_dato_q   <= 8'd0;
            pw_q         <= 1'b0;
            pr_q         <= 1'b0;
            rf_q         <= 1'b0;
            pw_dir_q     <= 8'd0;
            pw_dato_q    <= 8'd0;
            pr_dir_q     <= 8'd0;
            rf_cnt_q     <= '0;
            scan_idx_q   <= 8'd0;
            scan_act_q   <= 1'b0;
            dato_leido_q <= 8'd0;
            dir_leida_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            op_q         <= op_d;
            cur_dir_q    <= cur_dir_d;
            cur_dato_q   <= cur_dato_d;
            pw_q         <= pw_d;
            pr_q         <= pr_d;
            rf_q         <= rf_d;
            pw_dir_q     <= pw_dir_d;
            pw_dato_q    <= pw_dato_d;
            pr_dir_q     <= pr_dir_d;
            rf_cnt_q     <= rf_cnt_d;
            scan_idx_q   <= scan_idx_d;
            scan_act_q   <= scan_act_d;
            dato_leido_q <= dato_leido_d;
            dir_leida_q  <= dir_leida_d;
        end
    end

    // Bus pins decode straight from the registered state, so reset and
    // abort drop every strobe on the same edge the state returns to IDLE.
    assign in_addr = (state_q == S_ADDR_SET) || (state_q == S_ADDR_STB) ||
                     (state_q == S_ADDR_HOLD);
    assign in_data = (state_q == S_DATA_SET) || (state_q == S_DATA_STB) ||
                     (state_q == S_DATA_HOLD);

    assign cs_n   = !(in_addr || in_data);
    assign ad_sel = in_addr;
    assign ad_oe  = in_addr || (in_data && is_wr);
    assign ad_out = in_addr ? cur_dir_q :
                    (in_data && is_wr) ? cur_dato_q : 8'd0;
    assign wr_n   = !((state_q == S_ADDR_STB) || ((state_q == S_DATA_STB) && is_wr));
    assign rd_n   = !((state_q == S_DATA_STB) && !is_wr);

    assign listo           = (state_q == S_DONE);
    assign listo_lee       = (state_q == S_DONE) && !is_wr;
    assign listo_escribe   = done_wr;
    assign ocupado         = (state_q != S_IDLE);
    assign refresco_activo = scan_act_q;
    assign dato_leido      = dato_leido_q;
    assign dir_leida       = dir_leida_q;

endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_bus_rtc
//
// Self-checking bench for secuenciador_bus_rtc with PHASE_CYCLES=2,
// REFRESH_PERIOD=200, REFRESH_COUNT=3. A small RTC register model answers
// reads; completed transactions are checked against an expected queue, and
// each scenario task checks its own timing inline.
// -----------------------------------------------------------------------------
module tb_secuenciador_bus_rtc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pb_escribe = 1'b0;
    logic       pb_lee = 1'b0;
    logic [7:0] pb_dir = 8'd0;
    logic [7:0] pb_dato = 8'd0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, ad_sel, cs_n, rd_n, wr_n;
    logic [7:0] dato_leido, dir_leida;
    logic       listo, listo_lee, listo_escribe, ocupado, refresco_activo;

    // {is_write, address, data}
    logic [16:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  rtc_mem [256];
    logic [7:0]  bus_addr = 8'd0;
    logic [7:0]  mon_dir = 8'd0;
    logic [7:0]  mon_dato = 8'd0;

    always #5 clk = ~clk;

    assign ad_in = rtc_mem[bus_addr];

    secuenciador_bus_rtc #(
        .PHASE_CYCLES  (2),
        .REFRESH_PERIOD(200),
        .REFRESH_BASE  (8'h21),
        .REFRESH_COUNT (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pb_escribe     (pb_escribe),
        .pb_lee         (pb_lee),
        .pb_dir         (pb_dir),
        .pb_dato        (pb_dato),
        .ad_in          (ad_in),
        .ad_out         (ad_out),
        .ad_oe          (ad_oe),
        .ad_sel         (ad_sel),
        .cs_n           (cs_n),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .dato_leido     (dato_leido),
        .dir_leida      (dir_leida),
        .listo          (listo),
        .listo_lee      (listo_lee),
        .listo_escribe  (listo_escribe),
        .ocupado        (ocupado),
        .refresco_activo(refresco_activo)
    );

    // Bus monitor and scoreboard: the RTC model latches the address on the
    // address-phase wr_n strobe; every listo pops one expected completion.
    always @(negedge clk) begin
        logic [16:0] got;
        logic [16:0] exp;
        if (!cs_n && !wr_n && ad_sel) begin
            mon_dir  = ad_out;
            bus_addr = ad_out;
        end else if (!cs_n && !wr_n && !ad_sel) begin
            mon_dato = ad_out;
        end
        if (listo) begin
            got = listo_escribe ? {1'b1, mon_dir, mon_dato} : {1'b0, dir_leida, dato_leido};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h, nothing expected", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL sb_txn: got %h expected %h", got, exp);
                end
            end
            n_cmp++;
            if ((listo_lee ^ listo_escribe) !== 1'b1) begin
                n_err++;
                $display("FAIL sb_kind: lee=%b escribe=%b expected exactly one", listo_lee, listo_escribe);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        pb_escribe = 1'b0;
        pb_lee     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cs_n, rd_n, wr_n} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 111", {cs_n, rd_n, wr_n});
        end
        n_cmp++;
        if ({ad_sel, ad_oe, ad_out} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_bus: got %h expected 0", {ad_sel, ad_oe, ad_out});
        end
        n_cmp++;
        if ({dato_leido, dir_leida} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_regs: got %h expected 0", {dato_leido, dir_leida});
        end
        n_cmp++;
        if ({listo, listo_lee, listo_escribe, ocupado, refresco_activo} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_status: got %b expected 00000",
                     {listo, listo_lee, listo_escribe, ocupado, refresco_activo});
        end
    endtask

    task automatic test_write();
        int cs_low = 0, wr_low = 0, wr_pulses = 0, listo_cnt = 0, le_cnt = 0;
        int ocup_cnt = 0, listo_k = 0;
        logic prev_wr = 1'b1;
        do_reset();
        pb_escribe = 1'b1;
        pb_dir     = 8'h22;
        pb_dato    = 8'h45;
        exp_q.push_back({1'b1, 8'h22, 8'h45});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pb_escribe = 1'b0;
            if (!cs_n) cs_low++;
            if (!wr_n) wr_low++;
            if (!wr_n && prev_wr) wr_pulses++;
            prev_wr = wr_n;
            if (ocupado) ocup_cnt++;
            if (listo_escribe) le_cnt++;
            if (listo) begin
                listo_cnt++;
                listo_k = k;
            end
        end
        n_cmp++;
        if (cs_low !== 12) begin
            n_err++;
            $display("FAIL wr_cs_len: got %0d expected 12", cs_low);
        end
        n_cmp++;
        if (wr_pulses !== 2 || wr_low !== 4) begin
            n_err++;
            $display("FAIL wr_strobes: got %0d pulses/%0d cycles expected 2/4", wr_pulses, wr_low);
        end
        n_cmp++;
        if (listo_cnt !== 1 || le_cnt !== 1 || listo_k !== 13) begin
            n_err++;
            $display("FAIL wr_listo: got cnt=%0d esc=%0d at %0d expected 1/1 at 13",
                     listo_cnt, le_cnt, listo_k);
        end
        n_cmp++;
        if (ocup_cnt !== 13) begin
            n_err++;
            $display("FAIL wr_ocupado: got %0d expected 13", ocup_cnt);
        end
    endtask

    task automatic test_read();
        int rd_low = 0, oe_bad = 0, lee_cnt = 0, lee_k = 0;
        do_reset();
        pb_lee = 1'b1;
        pb_dir = 8'h23;
        exp_q.push_back({1'b0, 8'h23, 8'h17});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pb_lee = 1'b0;
            if (!rd_n) rd_low++;
            if (!cs_n && !ad_sel && ad_oe) oe_bad++;
            if (listo_lee) begin
                lee_cnt++;
                lee_k = k;
            end
        end
        n_cmp++;
        if (rd_low !== 2) begin
            n_err++;
            $display("FAIL rd_len: got %0d expected 2", rd_low);
        end
        n_cmp++;
        if (oe_bad !== 0) begin
            n_err++;
            $display("FAIL rd_oe: got %0d data cycles with ad_oe expected 0", oe_bad);
        end
        n_cmp++;
        if (lee_cnt !== 1 || lee_k !== 13) begin
            n_err++;
            $display("FAIL rd_listo: got %0d at %0d expected 1 at 13", lee_cnt, lee_k);
        end
        n_cmp++;
        if (dato_leido !== 8'h17 || dir_leida !== 8'h23) begin
            n_err++;
            $display("FAIL rd_regs: got %h/%h expected 17/23", dato_leido, dir_leida);
        end
    endtask

    task automatic test_back_to_back();
        int we_k = 0, le_k = 0, we_cnt = 0, le_cnt = 0, falls = 0, fall2_k = 0;
        logic prev_cs = 1'b1;
        do_reset();
        pb_escribe = 1'b1;
        pb_lee     = 1'b1;
        pb_dir     = 8'h30;
        pb_dato    = 8'hA5;
        exp_q.push_back({1'b1, 8'h30, 8'hA5});
        exp_q.push_back({1'b0, 8'h30, rtc_mem[8'h30]});
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            pb_escribe = 1'b0;
            pb_lee     = 1'b0;
            if (!cs_n && prev_cs) begin
                falls++;
                if (falls == 2) fall2_k = k;
            end
            prev_cs = cs_n;
            if (listo_escribe) begin
                we_cnt++;
                we_k = k;
            end
            if (listo_lee) begin
                le_cnt++;
                le_k = k;
            end
        end
        n_cmp++;
        if (we_cnt !== 1 || we_k !== 13) begin
            n_err++;
            $display("FAIL b2b_write: got %0d at %0d expected 1 at 13", we_cnt, we_k);
        end
        n_cmp++;
        if (le_cnt !== 1 || le_k !== 27) begin
            n_err++;
            $display("FAIL b2b_read: got %0d at %0d expected 1 at 27", le_cnt, le_k);
        end
        n_cmp++;
        if (fall2_k !== 15) begin
            n_err++;
            $display("FAIL b2b_gap: second cs_n fall at %0d expected 15", fall2_k);
        end
    endtask

    task automatic test_refresh();
        int first_k = 0, rf_hi = 0, lee_in_scan = 0, esc_in_scan = 0;
        logic seen = 1'b0;
        do_reset();
        exp_q.push_back({1'b0, 8'h21, rtc_mem[8'h21]});
        exp_q.push_back({1'b1, 8'h50, 8'h3C});
        exp_q.push_back({1'b0, 8'h22, rtc_mem[8'h22]});
        exp_q.push_back({1'b0, 8'h23, rtc_mem[8'h23]});
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            pb_escribe = 1'b0;
            if (refresco_activo) begin
                rf_hi++;
                if (listo_lee) lee_in_scan++;
                if (listo_escribe) esc_in_scan++;
                if (!seen) begin
                    seen       = 1'b1;
                    first_k    = k;
                    pb_escribe = 1'b1;
                    pb_dir     = 8'h50;
                    pb_dato    = 8'h3C;
                end
            end
        end
        n_cmp++;
        if (first_k !== 201) begin
            n_err++;
            $display("FAIL rf_start: got %0d expected 201", first_k);
        end
        n_cmp++;
        if (rf_hi !== 55) begin
            n_err++;
            $display("FAIL rf_span: got %0d expected 55", rf_hi);
        end
        n_cmp++;
        if (lee_in_scan !== 3 || esc_in_scan !== 1) begin
            n_err++;
            $display("FAIL rf_mix: got %0d reads/%0d writes expected 3/1", lee_in_scan, esc_in_scan);
        end
        n_cmp++;
        if (refresco_activo !== 1'b0) begin
            n_err++;
            $display("FAIL rf_end: got %b expected 0", refresco_activo);
        end
    endtask

    task automatic test_reset_abort();
        logic found = 1'b0;
        int listo_cnt = 0, listo_k = 0;
        do_reset();
        pb_escribe = 1'b1;
        pb_dir     = 8'h22;
        pb_dato    = 8'h45;
        for (int k = 1; k <= 30 && !found; k++) begin
            @(negedge clk);
            pb_escribe = 1'b0;
            if (!cs_n && ad_sel && !wr_n) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_wait: ADDR_STB got not seen expected within 30 cycles");
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cs_n, wr_n, ad_oe, ocupado, listo} !== 5'b11000) begin
            n_err++;
            $display("FAIL abort_pins: got %b expected 11000", {cs_n, wr_n, ad_oe, ocupado, listo});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (listo) listo_cnt++;
        end
        n_cmp++;
        if (listo_cnt !== 0) begin
            n_err++;
            $display("FAIL abort_listo: got %0d expected 0", listo_cnt);
        end
        pb_escribe = 1'b1;
        pb_dir     = 8'h40;
        pb_dato    = 8'h99;
        exp_q.push_back({1'b1, 8'h40, 8'h99});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pb_escribe = 1'b0;
            if (listo_escribe) begin
                listo_cnt++;
                listo_k = k;
            end
        end
        n_cmp++;
        if (listo_cnt !== 1 || listo_k !== 13) begin
            n_err++;
            $display("FAIL abort_recover: got %0d at %0d expected 1 at 13", listo_cnt, listo_k);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'($urandom_range(0, 255));
        rtc_mem[8'h23] = 8'h17;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_refresh();
        test_reset_abort();

        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
